// File: rtl/bw_frame_ctrl.sv
// Frame sequencer for the black-and-white converter: reads RGB pixels from a source RAM,
// reduces each to an 8-bit gray level and writes it to a destination RAM over valid/ack.
module bw_frame_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] num_pix,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [23:0]       src_rdata,
  output logic              dst_wr_valid,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_wdata,
  input  logic              dst_wr_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_base_q, dst_base_q, num_q, idx_q;
  logic [23:0]       pix_p1;
  logic              aborted_q, abort_pend_q;
  logic              accept_start, wr_done, abort_now, last_pix;

  function automatic logic [7:0] div3_sum(input logic [23:0] px);
    logic [9:0] sum;
    sum = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
    return 8'(sum / 10'd3);
  endfunction

  // Black is lifted to 1 so a written pixel can never be mistaken for an empty location.
  function automatic logic [7:0] clamp_nonzero(input logic [7:0] g);
    return (g == 8'd0) ? 8'd1 : g;
  endfunction

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    wr_done      = 1'b0;
    abort_now    = 1'b0;
    last_pix     = ((idx_q + IDX_ONE) == num_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = (num_pix == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        abort_now = abort;
        state_d   = abort ? S_FIN : S_WAIT;
      end
      S_WAIT: begin
        abort_now = abort;
        state_d   = abort ? S_FIN : S_WRITE;
      end
      S_WRITE: begin
        if (dst_wr_ack) begin
          wr_done = 1'b1;
          if (abort || abort_pend_q) begin
            abort_now = 1'b1;
            state_d   = S_FIN;
          end else if (last_pix) begin
            state_d = S_FIN;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        idx_q <= '0;
      end else if (wr_done) begin
        idx_q <= idx_q + IDX_ONE;
      end
      if (accept_start) begin
        aborted_q <= 1'b0;
      end else if (abort_now) begin
        aborted_q <= 1'b1;
      end
      // An abort seen mid-handshake is parked until the write is acked.
      if (state_q == S_WRITE && abort && !dst_wr_ack) begin
        abort_pend_q <= 1'b1;
      end else if (wr_done || accept_start) begin
        abort_pend_q <= 1'b0;
      end
    end
  end

  // Job parameters and the pixel stage carry no reset.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      src_base_q <= src_base;
      dst_base_q <= dst_base;
      num_q      <= num_pix;
    end
    if (state_q == S_WAIT) begin
      pix_p1 <= src_rdata;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign aborted      = aborted_q;
  assign src_rd_en    = (state_q == S_READ);
  assign src_addr     = src_rd_en ? (src_base_q + idx_q) : '0;
  assign dst_wr_valid = (state_q == S_WRITE);
  assign dst_addr     = dst_wr_valid ? (dst_base_q + idx_q) : '0;
  assign dst_wdata    = dst_wr_valid ? clamp_nonzero(div3_sum(pix_p1)) : 8'd0;

endmodule

// File: tb/tb_bw_frame_ctrl.sv
// Bench for bw_frame_ctrl: an event-timing reference model checked every cycle, plus
// literal expectations for the hand-worked frames.
module tb_bw_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] src_base, dst_base, num_pix;
  logic        busy, done, aborted, src_rd_en;
  logic [15:0] src_addr;
  logic [23:0] src_rdata;
  logic        dst_wr_valid;
  logic [15:0] dst_addr;
  logic [7:0]  dst_wdata;
  logic        dst_wr_ack;

  bw_frame_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .num_pix(num_pix),
    .busy(busy), .done(done), .aborted(aborted),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_wr_valid(dst_wr_valid), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .dst_wr_ack(dst_wr_ack)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [23:0] mem [0:65535];
  int ack_mode = 0;
  int ack_delay = 0;

  logic [15:0] rlog[$];
  logic [15:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_ab = 1'b0;
  int   start_cyc = 0;

  // reference model state: expected event cycles
  bit m_busy = 0, m_aborted = 0, m_in_wr = 0, m_abort_req = 0;
  int m_rd_at = -1, m_wait_at = -1, m_wr_from = -1, m_done_at = -1;
  int m_idx = 0, m_n = 0, m_sb = 0, m_db = 0;
  bit last_rst = 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int gray_m(input logic [23:0] p);
    int s;
    s = (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
    return (s == 0) ? 1 : s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // source RAM: data for a read strobe appears in the following cycle, garbage otherwise
  initial begin : ram
    logic        rd_pend;
    logic [15:0] rd_a;
    src_rdata = 24'd0;
    forever begin
      @(negedge clk);
      rd_pend = src_rd_en;
      rd_a    = src_addr;
      @(posedge clk);
      #1;
      src_rdata = rd_pend ? mem[rd_a] : 24'($urandom);
    end
  end

  // destination ack: 0 = tied high, 1 = random, 2 = after ack_delay valid cycles
  initial begin : ackdrv
    int vcnt;
    vcnt = 0;
    dst_wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dst_wr_valid) vcnt++;
      else vcnt = 0;
      case (ack_mode)
        0:       dst_wr_ack = 1'b1;
        1:       dst_wr_ack = 1'($urandom_range(0, 1));
        default: dst_wr_ack = dst_wr_valid && (vcnt > ack_delay);
      endcase
    end
  end

  // compare process
  initial begin : cmp
    bit e_rd, e_wait, e_val, e_done;
    forever begin
      @(negedge clk);
      if (last_rst) begin
        m_busy = 0; m_aborted = 0; m_in_wr = 0; m_abort_req = 0;
        m_rd_at = -1; m_wait_at = -1; m_wr_from = -1; m_done_at = -1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_rd_en", src_rd_en, 0);
        chk("rst_wr_valid", dst_wr_valid, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_dst_addr", dst_addr, 0);
        chk("rst_wdata", dst_wdata, 0);
      end else begin
        e_rd   = (cyc == m_rd_at);
        e_wait = (cyc == m_wait_at);
        if (cyc == m_wr_from) m_in_wr = 1;
        e_val  = m_in_wr;
        e_done = (cyc == m_done_at);
        chk("busy", busy, m_busy);
        chk("src_rd_en", src_rd_en, e_rd);
        chk("dst_wr_valid", dst_wr_valid, e_val);
        chk("done", done, e_done);
        chk("aborted", aborted, m_aborted);
        if (e_rd && src_rd_en)
          chk("src_addr", src_addr, (m_sb + m_idx) & 16'hFFFF);
        if (e_val && dst_wr_valid) begin
          chk("dst_addr", dst_addr, (m_db + m_idx) & 16'hFFFF);
          chk("dst_wdata", dst_wdata, gray_m(mem[16'(m_sb + m_idx)]));
        end
        if (src_rd_en) rlog.push_back(src_addr);
        if (dst_wr_valid && dst_wr_ack) begin
          wlog_a.push_back(dst_addr);
          wlog_d.push_back(dst_wdata);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          done_ab  = aborted;
        end
        // advance the model with this cycle's inputs
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_aborted = 0; m_abort_req = 0; m_in_wr = 0; m_idx = 0;
            m_sb = int'(src_base); m_db = int'(dst_base); m_n = int'(num_pix);
            if (m_n == 0) m_done_at = cyc + 1;
            else m_rd_at = cyc + 1;
          end
        end else begin
          if (e_rd) begin
            if (abort) begin m_done_at = cyc + 1; m_aborted = 1; end
            else m_wait_at = cyc + 1;
          end
          if (e_wait) begin
            if (abort) begin m_done_at = cyc + 1; m_aborted = 1; end
            else m_wr_from = cyc + 1;
          end
          if (e_val) begin
            if (abort) m_abort_req = 1;
            if (dst_wr_ack) begin
              m_in_wr = 0;
              m_idx++;
              if (m_abort_req) begin m_done_at = cyc + 1; m_aborted = 1; end
              else if (m_idx == m_n) m_done_at = cyc + 1;
              else m_rd_at = cyc + 1;
            end
          end
          if (e_done) m_busy = 0;
        end
      end
      last_rst = rst;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [15:0] sb, input logic [15:0] db, input int n,
                         input int am, input int ad, input int ab_off,
                         input bit ab_wr1, input bit bsy_start);
    int d0, k;
    bit ab_done;
    ack_mode = am;
    ack_delay = ad;
    rlog.delete(); wlog_a.delete(); wlog_d.delete();
    d0 = done_cnt;
    ab_done = 0;
    src_base = sb; dst_base = db; num_pix = 16'(n);
    start = 1'b1;
    abort = (ab_off == 0);
    start_cyc = cyc;
    next_cyc();
    k = 1;
    while (done_cnt == d0 && k < 3000) begin
      abort = (ab_off == k);
      if (ab_wr1 && !ab_done && dst_wr_valid && wlog_a.size() == 1) begin
        abort = 1'b1;
        ab_done = 1;
      end
      if (k == 1) begin
        src_base = 16'($urandom); dst_base = 16'($urandom); num_pix = 16'($urandom);
      end
      start = (bsy_start && k == 2);
      next_cyc();
      k++;
    end
    abort = 1'b0;
    start = 1'b0;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  initial begin : stim
    int n, am, ad, ab;
    logic [15:0] sb, db;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; num_pix = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 24'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    next_cyc();

    // primaries plus white
    mem[16'h0010] = 24'hFF0000; mem[16'h0011] = 24'h00FF00;
    mem[16'h0012] = 24'h0000FF; mem[16'h0013] = 24'hFFFFFF;
    run_job(16'h0010, 16'h0100, 4, 0, 0, -1, 0, 0);
    chk("a_nwr", wlog_a.size(), 4);
    for (int i = 0; i < 4; i++) chk("a_addr", wlog_a[i], 16'h0100 + i);
    chk("a_d0", wlog_d[0], 8'h55);
    chk("a_d1", wlog_d[1], 8'h55);
    chk("a_d2", wlog_d[2], 8'h55);
    chk("a_d3", wlog_d[3], 8'hFF);
    chk("a_done_lat", done_cyc - start_cyc, 13);
    chk("a_aborted", done_ab, 0);

    // dark pixels and a rounding case
    mem[16'h0200] = 24'h000000; mem[16'h0201] = 24'h000002;
    mem[16'h0202] = 24'h010101; mem[16'h0203] = 24'h7F8081;
    run_job(16'h0200, 16'h0300, 4, 1, 0, -1, 0, 0);
    chk("b_nwr", wlog_d.size(), 4);
    chk("b_d0", wlog_d[0], 8'h01);
    chk("b_d1", wlog_d[1], 8'h01);
    chk("b_d2", wlog_d[2], 8'h01);
    chk("b_d3", wlog_d[3], 8'h80);

    // empty frame
    run_job(16'h0400, 16'h0500, 0, 0, 0, -1, 0, 0);
    chk("z_nrd", rlog.size(), 0);
    chk("z_nwr", wlog_a.size(), 0);
    chk("z_aborted", done_ab, 0);

    // abort during the slow write of pixel 1 of 8
    for (int i = 0; i < 8; i++) mem[16'h0700 + i] = 24'($urandom);
    run_job(16'h0700, 16'h0800, 8, 2, 5, -1, 1, 0);
    chk("ab_nwr", wlog_a.size(), 2);
    chk("ab_addr1", wlog_a[1], 16'h0801);
    chk("ab_flag", done_ab, 1);

    // address wrap with a start pulse while busy
    mem[16'hFFFE] = 24'h123456; mem[16'hFFFF] = 24'h654321; mem[16'h0000] = 24'h0A0B0C;
    run_job(16'hFFFE, 16'h0040, 3, 0, 0, -1, 0, 1);
    chk("w_nrd", rlog.size(), 3);
    chk("w_rd0", rlog[0], 16'hFFFE);
    chk("w_rd1", rlog[1], 16'hFFFF);
    chk("w_rd2", rlog[2], 16'h0000);
    chk("w_aborted", done_ab, 0);

    // abort while idle is ignored; start together with abort runs normally
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    next_cyc();
    run_job(16'h0020, 16'h0030, 2, 0, 0, 0, 0, 0);
    chk("sa_nwr", wlog_a.size(), 2);
    chk("sa_aborted", done_ab, 0);

    // reset in the middle of a held write
    ack_mode = 2; ack_delay = 5;
    src_base = 16'h0900; dst_base = 16'h0A00; num_pix = 16'd3;
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    for (int k = 0; k < 50 && !dst_wr_valid; k++) next_cyc();
    chk("r_reach_write", dst_wr_valid, 1);
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    chk("r_valid_drop", dst_wr_valid, 0);
    chk("r_busy", busy, 0);
    next_cyc();

    // randomized frames
    for (int j = 0; j < 40; j++) begin
      n  = $urandom_range(0, 10);
      sb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
      db = 16'($urandom);
      am = $urandom_range(0, 2);
      ad = $urandom_range(0, 4);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3 * n + 4) : -1;
      for (int i = 0; i < n; i++)
        mem[16'(int'(sb) + i)] = ($urandom_range(0, 3) == 0) ?
          {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)} : 24'($urandom);
      run_job(sb, db, n, am, ad, ab, 0, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) next_cyc();
    end

    next_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
